// File: rtl/fifo_stream_reader_pkg.sv
// Shared types for the FIFO-to-stream reader.
//   rd_state_e : occupancy of the two-entry output buffer (EMPTY / ONE / TWO).
package fifo_stream_reader_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_stream_reader.sv
// Drains a push/pop FIFO from its pop side and presents the head elements as a
// valid/ready stream through a two-entry registered buffer (head + skid).
// Pops depend only on registered occupancy and FIFO flags, so there is no
// combinational path from ready_i to fifo_pop_o, nor from fifo_data_i to data_o.
//
// Ports:
//   clk_i        : clock, rising edge
//   rst_i        : synchronous active-high reset (priority over flush_i)
//   flush_i      : drop buffered elements (also flushes the upstream FIFO)
//   fifo_empty_i : upstream FIFO empty flag
//   fifo_data_i  : upstream FIFO head element, valid while !fifo_empty_i
//   fifo_pop_o   : pop request to the upstream FIFO
//   valid_o      : stream valid
//   ready_i      : stream ready
//   data_o       : stream data
//   busy_o       : buffer holds at least one element
//   pop_cnt_o    : wrapping count of elements popped since reset
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter type         dtype      = logic [DATA_WIDTH-1:0],
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 fifo_empty_i,
  input  dtype                 fifo_data_i,
  output logic                 fifo_pop_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output dtype                 data_o,
  output logic                 busy_o,
  output logic [CNT_WIDTH-1:0] pop_cnt_o
);

  rd_state_e            state_q, state_d;
  dtype                 head_q, head_d;
  dtype                 skid_q, skid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 hs;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and buffer datapath
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    cnt_d   = fifo_pop_o ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    if (flush_i) begin
      // Register contents are left as-is; only occupancy is cleared.
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (fifo_pop_o) begin
            head_d  = fifo_data_i;
            state_d = ONE;
          end
        end
        ONE: begin
          if (fifo_pop_o && hs) begin
            head_d = fifo_data_i;
          end else if (fifo_pop_o) begin
            skid_d  = fifo_data_i;
            state_d = TWO;
          end else if (hs) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          // No pop can occur here, so the skid entry simply moves up.
          if (hs) begin
            head_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Outputs: registered-state decodes plus FIFO/flush/reset gating only
  always_comb begin
    valid_o    = (state_q != EMPTY);
    busy_o     = valid_o;
    data_o     = head_q;
    pop_cnt_o  = cnt_q;
    hs         = valid_o && ready_i;
    fifo_pop_o = !rst_i && !fifo_empty_i && !flush_i && (state_q != TWO);
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Drains a push/pop FIFO (full/empty/data/push/pop interface) from its pop side and presents the head elements as a valid/ready stream with a two-entry registered output buffer. It sits between any FIFO in the design and a stream consumer. It decouples the consumer's `ready_i` from the FIFO's `pop` input so no combinational path runs between them, while sustaining one element per cycle.

## Interface
Parameters:
- `DATA_WIDTH`, 32, element width when `dtype` is left at its default.
- `dtype`, `logic [DATA_WIDTH-1:0]`, element type.
- `CNT_WIDTH`, 16, width of the pop counter (≥1).

Ports:
- `clk_i` in 1: the single clock; all logic is on its rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `flush_i` in 1: discards buffered elements. The same signal drives the upstream FIFO's flush.
- `fifo_empty_i` in 1: empty flag from the upstream FIFO.
- `fifo_data_i` in dtype: head element from the FIFO. Valid combinationally whenever `fifo_empty_i`=0.
- `fifo_pop_o` out 1: pop request to the FIFO.
- `valid_o` out 1: stream valid.
- `ready_i` in 1: stream ready.
- `data_o` out dtype: stream data.
- `busy_o` out 1: buffer holds at least one element.
- `pop_cnt_o` out CNT_WIDTH: running count of elements popped.

## Operation
- The buffer has two registers, `head` (drives `data_o`) and `skid`, plus a state that encodes occupancy: EMPTY, ONE, TWO.
- `fifo_pop_o = !fifo_empty_i && !flush_i && state != TWO`.
  - It is purely a function of registered state and FIFO flags.
  - It never depends on `ready_i`.
- `valid_o = (state != EMPTY)` and `busy_o = valid_o`. Both are registered-state decodes.
- Define `pop = fifo_pop_o` and `hs = valid_o && ready_i`. State transitions, applied when `flush_i`=0:
  - EMPTY, with pop: load `head` from `fifo_data_i`, go to ONE.
  - ONE, with pop and hs: reload `head`, stay in ONE.
  - ONE, with pop and no hs: load `skid`, go to TWO.
  - ONE, with hs and no pop: go to EMPTY.
  - TWO, with hs: `head <= skid`, go to ONE. A pop is impossible in TWO.
  - All other combinations: hold.
- Ordering is strict FIFO; no element is duplicated or dropped except by flush.
- Stream protocol:
  - Once `valid_o` is asserted, `valid_o` and `data_o` stay stable until `hs`.
  - `valid_o` never depends on `ready_i`.
- Flush, when `flush_i`=1 in a cycle:
  - The next state is EMPTY regardless of hs or pop.
  - `fifo_pop_o` is 0 in that cycle.
  - Register contents are don't-care but unchanged.
- Pop counter:
  - `pop_cnt_o` increments by 1 on every cycle with `fifo_pop_o`=1.
  - It wraps modulo 2^CNT_WIDTH.
  - It is cleared only by reset; flush does not clear it.
- Reset:
  - State goes to EMPTY; `head`, `skid` and `pop_cnt_o` go to 0.
  - Outputs after reset: `valid_o`=0, `busy_o`=0, `data_o`=0, `fifo_pop_o`=0 while `rst_i`=1.
  - Reset mid-transfer discards all buffered elements with no further pops.
  - Reset has priority over flush.

## Timing
- Latency: an element at the FIFO head popped at edge t is on `data_o` with `valid_o`=1 in the cycle after t. This is 1 cycle FIFO-head-to-stream.
- Throughput: 1 element/cycle sustained when the FIFO is non-empty and `ready_i`=1 (steady state ONE).
- Backpressure: with `ready_i`=0, at most 2 elements are popped before `fifo_pop_o` drops. `fifo_pop_o` is 0 in the cycle after state reaches TWO.
- After `ready_i` reasserts in TWO, `fifo_pop_o` rises in the next cycle (state ONE).
- No combinational paths from `ready_i` to `fifo_pop_o`, or from `fifo_data_i` to `data_o`.

## Structure
- Shared package `fifo_stream_reader_pkg` holds `rd_state_e`, a 2-bit enum with EMPTY=0, ONE=1, TWO=2.
- Single flat module; no sub-module. The upstream FIFO is instantiated by the parent, not inside this block.

## Test plan
- Reset: hold `rst_i`=1 for 3 cycles with FIFO non-empty -> `fifo_pop_o`=0, `valid_o`=0, `data_o`=0, `pop_cnt_o`=0.
- Streaming: FIFO preloaded with 0x10..0x17, `ready_i`=1 -> stream carries 0x10..0x17 in 8 consecutive cycles starting 1 cycle after the first pop; `pop_cnt_o`=8.
- Backpressure:
  - Stimulus: FIFO holds 0xA..0xD, `ready_i`=0 for 5 cycles, then 1.
  - Exactly 2 pops occur, then `data_o` holds stable at 0xA.
  - After release, stream carries 0xA,0xB,0xC,0xD in order.
- Flush: state TWO holding 0x1,0x2 with `ready_i`=0, assert `flush_i` for 1 cycle -> next cycle `valid_o`=0; `fifo_pop_o`=0 during the flush cycle; `pop_cnt_o` unchanged.
- Random stress: random `fifo_empty_i` and `ready_i` over 10k cycles with a scoreboard -> in-order, no loss or duplication, and a stable-while-stalled assertion always holds.
- Counter wrap: CNT_WIDTH=4, 17 pops -> `pop_cnt_o`=1.
